// File: rtl/change_dispenser.sv
// change_dispenser: greedy largest-first payout of a latched balance over a valid/ready coin hopper.
// Define COIN_STOCK_EN to track per-denomination stock and skip empty denominations.
module change_dispenser #(
    parameter int COIN0_VALUE = 100,
    parameter int COIN1_VALUE = 500,
    parameter int COIN2_VALUE = 1000,
    parameter int BAL_W       = 16,
    parameter int STOCK_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic [BAL_W-1:0]     i_balance,
    input  logic                 i_coin_ready,
    input  logic                 i_stock_load,
    input  logic [3*STOCK_W-1:0] i_stock_count,
    output logic [2:0]           o_return_coin,
    output logic                 o_coin_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [BAL_W-1:0]     o_remaining,
    output logic                 o_short
);
    localparam logic [1:0] IDLE = 2'd0, PAY = 2'd1, DONE = 2'd2;
    localparam logic [BAL_W-1:0] C0 = BAL_W'(COIN0_VALUE);
    localparam logic [BAL_W-1:0] C1 = BAL_W'(COIN1_VALUE);
    localparam logic [BAL_W-1:0] C2 = BAL_W'(COIN2_VALUE);

    logic [1:0]       state_q, state_d;
    logic [BAL_W-1:0] rem_q, rem_d, cval;
    logic [2:0]       coin_q, coin_d, pick, avail;
    logic             short_q, short_d, xfer, accept;

    assign accept = state_q == IDLE && i_start;
    assign xfer   = state_q == PAY && coin_q != 3'b000 && i_coin_ready;
    assign cval   = coin_q[2] ? C2 : coin_q[1] ? C1 : coin_q[0] ? C0 : '0;

`ifdef COIN_STOCK_EN
    logic [2:0][STOCK_W-1:0] stock_q, stock_d;
    always_comb begin
        stock_d = stock_q;
        for (int i = 0; i < 3; i++)
            if (xfer && coin_q[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
        if (i_stock_load) stock_d = i_stock_count;
    end
    assign avail = {stock_d[2] != '0, stock_d[1] != '0, stock_d[0] != '0};
    always_ff @(posedge clk) stock_q <= !reset_n ? '0 : stock_d;
`else
    logic unused_stock;
    assign unused_stock = ^{i_stock_load, i_stock_count};
    assign avail = 3'b111;
`endif

    // The next coin is chosen from next-state values so the presented coin comes straight from a register.
    assign rem_d   = accept ? i_balance : xfer ? rem_q - cval : rem_q;
    assign pick    = (rem_d >= C2 && avail[2]) ? 3'b100 :
                     (rem_d >= C1 && avail[1]) ? 3'b010 :
                     (rem_d >= C0 && avail[0]) ? 3'b001 : 3'b000;
    assign state_d = state_q == IDLE ? (i_start ? PAY : IDLE) :
                     state_q == PAY  ? (pick == 3'b000 ? DONE : PAY) : IDLE;
    assign coin_d  = state_d == PAY ? pick : 3'b000;
    assign short_d = accept ? 1'b0 :
                     (state_q == PAY && state_d == DONE) ? rem_d >= C0 : short_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            coin_q  <= 3'b000;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
            short_q <= short_d;
        end
    end

    assign o_return_coin = coin_q;
    assign o_coin_valid  = coin_q != 3'b000;
    assign o_busy        = state_q == PAY;
    assign o_done        = state_q == DONE;
    assign o_remaining   = rem_q;
    assign o_short       = short_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven payout vectors with a coin scoreboard, plus backpressure,
// ignored-restart, reset-abort and stock-limit sequences.
module tb_change_dispenser;
    logic        clk = 0, reset_n = 0, i_start = 0, i_coin_ready = 1, i_stock_load = 0;
    logic [15:0] i_balance = 0;
    logic [23:0] i_stock_count = 0;
    logic [2:0]  o_return_coin;
    logic        o_coin_valid, o_busy, o_done, o_short;
    logic [15:0] o_remaining;

    int          total = 0, bad = 0;
    logic [2:0]  q[$];
    int          mstock[3];
    logic        hold_pend = 0;
    logic [2:0]  hold_coin = 0;
    logic [15:0] hold_rem = 0;

    typedef struct {
        logic [15:0] bal;
        logic [15:0] rem;
        int          dn;
        logic        shrt;
    } vec_t;
    vec_t vt[7];

    change_dispenser dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_balance(i_balance),
        .i_coin_ready(i_coin_ready), .i_stock_load(i_stock_load), .i_stock_count(i_stock_count),
        .o_return_coin(o_return_coin), .o_coin_valid(o_coin_valid), .o_busy(o_busy),
        .o_done(o_done), .o_remaining(o_remaining), .o_short(o_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push_model(input logic [15:0] bal);
        int val[3] = '{100, 500, 1000};
        int r = int'(bal);
        logic [2:0] c;
        for (int d = 2; d >= 0; d--) begin
`ifdef COIN_STOCK_EN
            while (r >= val[d] && mstock[d] > 0) begin
                mstock[d]--;
`else
            while (r >= val[d]) begin
`endif
                c = 3'(1 << d);
                q.push_back(c);
                r -= val[d];
            end
        end
    endtask

    task automatic load_stock(input int s2, input int s1, input int s0);
        @(posedge clk); #1;
        i_stock_load = 1;
        i_stock_count = {8'(s2), 8'(s1), 8'(s0)};
        mstock[2] = s2; mstock[1] = s1; mstock[0] = s0;
        @(posedge clk); #1;
        i_stock_load = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_coin"}, o_return_coin, 0);
        chk({tag, "_valid"}, o_coin_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rem"}, o_remaining, 0);
        chk({tag, "_short"}, o_short, 0);
    endtask

    task automatic run_payout(input logic [15:0] bal, input logic [15:0] rem, input int dn,
                              input logic shrt, input bit restart);
        int n;
        @(posedge clk); #1;
        i_start = 1; i_balance = bal;
        push_model(bal);
        @(posedge clk); #1;
        i_start = restart; i_balance = 16'd500;
        chk("busy", o_busy, 1);
        chk("short_clr", o_short, 0);
        n = 1;
        while (!o_done && n < 200) begin
            @(posedge clk); #1;
            i_start = 0;
            n++;
        end
        chk("done_cycle", n, dn);
        chk("busy_done", o_busy, 0);
        chk("rem", o_remaining, rem);
        chk("short", o_short, shrt);
        chk("sb_empty", q.size(), 0);
        @(posedge clk); #1;
        chk("done_pulse", o_done, 0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pend <= 0;
        end else begin
            if (hold_pend) begin
                chk("hold_coin", o_return_coin, hold_coin);
                chk("hold_rem", o_remaining, hold_rem);
            end
            hold_pend <= o_coin_valid && !i_coin_ready;
            hold_coin <= o_return_coin;
            hold_rem  <= o_remaining;
            if (o_coin_valid && i_coin_ready) begin
                if (q.size() == 0) chk("sb_extra", o_return_coin, 0);
                else chk("sb_coin", o_return_coin, q.pop_front());
            end
        end
    end

    initial begin
        vt[0] = '{16'd1600,  16'd0,  4,  1'b0};
        vt[1] = '{16'd1100,  16'd0,  3,  1'b0};
        vt[2] = '{16'd250,   16'd50, 3,  1'b0};
        vt[3] = '{16'd0,     16'd0,  2,  1'b0};
        vt[4] = '{16'd50,    16'd50, 2,  1'b0};
        vt[5] = '{16'd3800,  16'd0,  8,  1'b0};
        vt[6] = '{16'd65535, 16'd35, 67, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1;
        load_stock(255, 255, 255);

        for (int i = 0; i < 7; i++)
            run_payout(vt[i].bal, vt[i].rem, vt[i].dn, vt[i].shrt, 1'b0);

        // backpressure: 1000 held for three stalled cycles, then 100
        @(posedge clk); #1;
        i_coin_ready = 0; i_start = 1; i_balance = 16'd1100;
        push_model(16'd1100);
        @(posedge clk); #1;
        i_start = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_coin", o_return_coin, 3'b100);
            chk("bp_rem", o_remaining, 1100);
            @(posedge clk); #1;
        end
        i_coin_ready = 1;
        @(posedge clk); #1;
        chk("bp_rem1", o_remaining, 100);
        chk("bp_coin1", o_return_coin, 3'b001);
        @(posedge clk); #1;
        chk("bp_done", o_done, 1);
        chk("bp_rem0", o_remaining, 0);
        chk("bp_sb_empty", q.size(), 0);

        run_payout(16'd1600, 16'd0, 4, 1'b0, 1'b1);

        // reset after the first coin of 1600 aborts the payout
        @(posedge clk); #1;
        i_start = 1; i_balance = 16'd1600;
        push_model(16'd1600);
        @(posedge clk); #1;
        i_start = 0;
        chk("rst_first", o_return_coin, 3'b100);
        @(posedge clk); #1;
        reset_n = 0;
        @(posedge clk); #1;
        chk_reset_outputs("abort");
        q.delete();
        reset_n = 1;
        load_stock(255, 255, 255);
        run_payout(16'd1600, 16'd0, 4, 1'b0, 1'b0);

`ifdef COIN_STOCK_EN
        load_stock(1, 0, 3);
        run_payout(16'd2500, 16'd1200, 5, 1'b1, 1'b0);
        load_stock(255, 255, 255);
        run_payout(16'd1600, 16'd0, 4, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
